// File: rtl/bcd_display_scan_if.sv
// Handshake and display bundle between the BCD converter, the scan driver and the panel.
interface bcd_display_scan_if;
  logic [15:0] bcd_code;
  logic        bcd_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        display_valid;

  modport master (
    output bcd_code,
    output bcd_ready,
    input  an,
    input  seg,
    input  dp,
    input  display_valid
  );

  modport slave (
    input  bcd_code,
    input  bcd_ready,
    output an,
    output seg,
    output dp,
    output display_valid
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Captures a packed 4-digit BCD result on a synchronised ready rise and scans it onto a
// common-anode seven-segment display with leading-zero blanking and a dash for bad nibbles.
module bcd_display_scan #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input logic               i_clk,
  input logic               i_reset,
  bcd_display_scan_if.slave disp_if
);

  localparam int unsigned PcntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(REFRESH_DIV - 1);

  logic             r_rdy_s1, r_rdy_s2, r_rdy_d;
  logic             w_capture;
  logic [15:0]      r_hold;
  logic             r_valid;
  logic [PcntW-1:0] r_pcnt;
  logic [1:0]       r_idx;
  logic             w_tc;
  logic [3:0]       w_nib;
  logic [3:0]       w_zero;
  logic [3:0]       w_blank;
  logic [3:0]       w_an, r_an;
  logic [6:0]       w_seg, r_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // bcd_ready is asynchronous; only the synchronised rise triggers a capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
      r_rdy_d  <= 1'b0;
    end else begin
      r_rdy_s1 <= disp_if.bcd_ready;
      r_rdy_s2 <= r_rdy_s1;
      r_rdy_d  <= r_rdy_s2;
    end
  end

  assign w_capture = r_rdy_s2 & ~r_rdy_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold  <= 16'h0000;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_hold  <= disp_if.bcd_code;
      r_valid <= 1'b1;
    end
  end

  assign w_tc = (r_pcnt == PcntMax);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pcnt <= '0;
      r_idx  <= 2'd0;
    end else begin
      r_pcnt <= w_tc ? '0 : r_pcnt + 1'b1;
      if (w_tc) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign w_zero[0] = (r_hold[3:0]   == 4'h0);
  assign w_zero[1] = (r_hold[7:4]   == 4'h0);
  assign w_zero[2] = (r_hold[11:8]  == 4'h0);
  assign w_zero[3] = (r_hold[15:12] == 4'h0);

  // A digit is blank only if it and every more-significant nibble are zero.
  assign w_blank[0] = 1'b0;
  assign w_blank[1] = BLANK_LEADING & w_zero[3] & w_zero[2] & w_zero[1];
  assign w_blank[2] = BLANK_LEADING & w_zero[3] & w_zero[2];
  assign w_blank[3] = BLANK_LEADING & w_zero[3];

  always_comb begin
    w_nib = 4'h0;
    unique case (r_idx)
      2'd0: w_nib = r_hold[3:0];
      2'd1: w_nib = r_hold[7:4];
      2'd2: w_nib = r_hold[11:8];
      2'd3: w_nib = r_hold[15:12];
      default: w_nib = 4'h0;
    endcase
  end

  always_comb begin
    w_an  = 4'b1111;
    w_seg = 7'h7F;
    if (r_valid && !w_blank[r_idx]) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = seg_decode(w_nib);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign disp_if.an            = r_an;
  assign disp_if.seg           = r_seg;
  assign disp_if.dp            = 1'b1;
  assign disp_if.display_valid = r_valid;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: three instances (div 4 blanking, div 4 no blanking, div 1 blanking)
// share stimulus; expected outputs are queued per cycle from a bench-side display model.
module tb_bcd_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_display_scan_if if0 ();
  bcd_display_scan_if if1 ();
  bcd_display_scan_if if2 ();

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .disp_if(if0.slave));
  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .disp_if(if1.slave));
  bcd_display_scan #(.REFRESH_DIV(1), .BLANK_LEADING(1'b1)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .disp_if(if2.slave));

  logic [3:0] mon_an  [3];
  logic [6:0] mon_seg [3];
  logic       mon_vld [3];
  logic       mon_dp  [3];
  assign mon_an[0] = if0.an;  assign mon_seg[0] = if0.seg;
  assign mon_vld[0] = if0.display_valid;  assign mon_dp[0] = if0.dp;
  assign mon_an[1] = if1.an;  assign mon_seg[1] = if1.seg;
  assign mon_vld[1] = if1.display_valid;  assign mon_dp[1] = if1.dp;
  assign mon_an[2] = if2.an;  assign mon_seg[2] = if2.seg;
  assign mon_vld[2] = if2.display_valid;  assign mon_dp[2] = if2.dp;

  // Rising edges since reset release.
  int unsigned n_edge;
  always @(posedge clk or posedge rst) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  typedef struct packed {
    logic [2:0]      vld;
    logic [2:0][3:0] an;
    logic [2:0][6:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] disp_val;
  logic        disp_vld;
  logic [15:0] pend_val;
  logic        pend_on;
  int unsigned pend_edge;

  function automatic logic [10:0] model_out(input int unsigned div, input bit bl,
                                            input logic [15:0] v, input logic vld,
                                            input int unsigned n);
    int unsigned idx;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  an_v;
    logic [6:0]  s;
    if (!vld) return {4'hF, 7'h7F};
    idx   = ((n - 1) / div) % 4;
    upper = v >> (idx * 4);
    nib   = upper[3:0];
    if (bl && idx != 0 && upper == 16'h0000) return {4'hF, 7'h7F};
    case (nib)
      4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
      4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
      4'd8: s = 7'h00;  4'd9: s = 7'h10;
      default: s = 7'h3F;
    endcase
    an_v = 4'b0001 << idx;
    return {~an_v, s};
  endfunction

  // Queue expectations for the next cnt rising edges.
  task automatic push_exp(input int unsigned cnt);
    exp_t        e;
    logic [15:0] v;
    logic        sv, dv;
    logic [10:0] r;
    int unsigned n;
    for (int unsigned i = 1; i <= cnt; i++) begin
      n  = n_edge + i;
      sv = disp_vld || (pend_on && n >= pend_edge);
      dv = disp_vld || (pend_on && n + 1 >= pend_edge);
      v  = (pend_on && n >= pend_edge) ? pend_val : disp_val;
      for (int k = 0; k < 3; k++) begin
        r         = model_out((k == 2) ? 1 : 4, (k != 1), v, sv, n);
        e.an[k]   = r[10:7];
        e.seg[k]  = r[6:0];
        e.vld[k]  = dv;
      end
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic [15:0] code, input logic rdy);
    if0.bcd_code = code;  if1.bcd_code = code;  if2.bcd_code = code;
    if0.bcd_ready = rdy;  if1.bcd_ready = rdy;  if2.bcd_ready = rdy;
  endtask

  task automatic idle(input int unsigned cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after edge m: capture lands at m+3, display shows it after m+4.
  task automatic raise_ready(input logic [15:0] code);
    if (pend_on) begin
      disp_val = pend_val;
      disp_vld = 1'b1;
    end
    drive(code, 1'b1);
    pend_on   = 1'b1;
    pend_val  = code;
    pend_edge = n_edge + 4;
  endtask

  task automatic recapture(input logic [15:0] code);
    drive(if0.bcd_code, 1'b0);
    idle(3);
    raise_ready(code);
  endtask

  task automatic model_reset();
    disp_val = 16'h0000;
    disp_vld = 1'b0;
    pend_on  = 1'b0;
    pend_val = 16'h0000;
    pend_edge = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    model_reset();
    drive(16'h0000, 1'b0);
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (mon_an[k] !== 4'hF || mon_seg[k] !== 7'h7F || mon_dp[k] !== 1'b1 ||
            mon_vld[k] !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_held inst%0d: an=%b seg=%h dp=%b vld=%b, want 1111/7f/1/0",
                   k, mon_an[k], mon_seg[k], mon_dp[k], mon_vld[k]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    push_exp(40);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (mon_an[k] !== e.an[k] || mon_seg[k] !== e.seg[k] || mon_vld[k] !== e.vld[k] ||
            mon_dp[k] !== 1'b1) begin
          n_errors++;
          $display("FAIL reset_idle inst%0d edge%0d: an=%b seg=%h vld=%b dp=%b, want %b/%h/%b/1",
                   k, n_edge, mon_an[k], mon_seg[k], mon_vld[k], mon_dp[k],
                   e.an[k], e.seg[k], e.vld[k]);
        end
      end
    end
  endtask

  task automatic test_capture_scan();
    exp_t e;
    // Make the capture edge coincide with a digit advance on the div-4 instances.
    while (((n_edge + 3) % 4) != 0) idle(1);
    raise_ready(16'h1234);
    push_exp(40);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (mon_an[k] !== e.an[k] || mon_seg[k] !== e.seg[k] || mon_vld[k] !== e.vld[k] ||
            mon_dp[k] !== 1'b1) begin
          n_errors++;
          $display("FAIL capture_scan inst%0d edge%0d: an=%b seg=%h vld=%b dp=%b, want %b/%h/%b/1",
                   k, n_edge, mon_an[k], mon_seg[k], mon_vld[k], mon_dp[k],
                   e.an[k], e.seg[k], e.vld[k]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    exp_t        e;
    logic [15:0] codes [3];
    codes[0] = 16'h0007;
    codes[1] = 16'h0000;
    codes[2] = 16'h0100;
    for (int p = 0; p < 3; p++) begin
      recapture(codes[p]);
      push_exp(24);
      for (int c = 0; c < 24; c++) begin
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (mon_an[k] !== e.an[k] || mon_seg[k] !== e.seg[k] || mon_vld[k] !== e.vld[k]) begin
            n_errors++;
            $display("FAIL blanking_%h inst%0d edge%0d: an=%b seg=%h vld=%b, want %b/%h/%b",
                     codes[p], k, n_edge, mon_an[k], mon_seg[k], mon_vld[k],
                     e.an[k], e.seg[k], e.vld[k]);
          end
        end
      end
    end
  endtask

  task automatic test_invalid();
    exp_t        e;
    logic [15:0] codes [2];
    codes[0] = 16'h00A5;
    codes[1] = 16'hF09C;
    for (int p = 0; p < 2; p++) begin
      recapture(codes[p]);
      push_exp(24);
      for (int c = 0; c < 24; c++) begin
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (mon_an[k] !== e.an[k] || mon_seg[k] !== e.seg[k] || mon_vld[k] !== e.vld[k]) begin
            n_errors++;
            $display("FAIL invalid_%h inst%0d edge%0d: an=%b seg=%h vld=%b, want %b/%h/%b",
                     codes[p], k, n_edge, mon_an[k], mon_seg[k], mon_vld[k],
                     e.an[k], e.seg[k], e.vld[k]);
          end
        end
      end
    end
  endtask

  task automatic test_handshake();
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: recapture(16'h1234);
        1: drive(16'h5678, 1'b1);          // code change while ready held: ignored
        2: recapture(16'h5678);            // 3-cycle low then rise
        default: begin                     // sub-cycle low pulse between edges: ignored
          drive(16'h9999, 1'b0);
          @(negedge clk);
          drive(16'h9999, 1'b1);
        end
      endcase
      push_exp(20);
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (mon_an[k] !== e.an[k] || mon_seg[k] !== e.seg[k] || mon_vld[k] !== e.vld[k]) begin
            n_errors++;
            $display("FAIL handshake_p%0d inst%0d edge%0d: an=%b seg=%h vld=%b, want %b/%h/%b",
                     p, k, n_edge, mon_an[k], mon_seg[k], mon_vld[k],
                     e.an[k], e.seg[k], e.vld[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: recapture(16'h1234);
        1: begin
          #2 rst = 1'b1;
          #1;
          for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (mon_an[k] !== 4'hF || mon_seg[k] !== 7'h7F || mon_dp[k] !== 1'b1 ||
                mon_vld[k] !== 1'b0) begin
              n_errors++;
              $display("FAIL reset_mid_async inst%0d: an=%b seg=%h dp=%b vld=%b, want 1111/7f/1/0",
                       k, mon_an[k], mon_seg[k], mon_dp[k], mon_vld[k]);
            end
          end
          drive(16'h1234, 1'b0);
          @(posedge clk);
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          model_reset();
        end
        default: raise_ready(16'h4321);
      endcase
      push_exp(20);
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (mon_an[k] !== e.an[k] || mon_seg[k] !== e.seg[k] || mon_vld[k] !== e.vld[k]) begin
            n_errors++;
            $display("FAIL reset_mid_p%0d inst%0d edge%0d: an=%b seg=%h vld=%b, want %b/%h/%b",
                     p, k, n_edge, mon_an[k], mon_seg[k], mon_vld[k],
                     e.an[k], e.seg[k], e.vld[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture_scan();
    test_blanking();
    test_invalid();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
